// File: rtl/cache_arbiter.sv
// Serialises I-cache and D-cache line requests onto one cacheline adaptor port.
// Ports: clk/rst, i_* (I-cache), d_* (D-cache), a_* (adaptor), busy.
// Config: define CACHE_ARB_RR_EN for round-robin ties; otherwise D-cache wins ties.
module cache_arbiter (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_read,
   input  logic [31:0]  i_address,
   output logic         i_resp,
   output logic [255:0] i_rdata,
   input  logic         d_read,
   input  logic         d_write,
   input  logic [31:0]  d_address,
   input  logic [255:0] d_wdata,
   output logic         d_resp,
   output logic [255:0] d_rdata,
   output logic         a_read,
   output logic         a_write,
   output logic [31:0]  a_address,
   output logic [255:0] a_wdata,
   input  logic [255:0] a_rdata,
   input  logic         a_resp,
   output logic         busy
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      RECOVER
   } state_t;

   state_t state;
   logic   d_req;
   logic   pick_d;

   assign d_req = d_read | d_write;

`ifdef CACHE_ARB_RR_EN
   // Set when the D-cache took the most recent grant.
   logic last_d;
   assign pick_d = d_req & (~i_read | ~last_d);
`else
   assign pick_d = d_req;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         a_read    <= 1'b0;
         a_write   <= 1'b0;
         a_address <= 32'h0;
         a_wdata   <= 256'h0;
`ifdef CACHE_ARB_RR_EN
         last_d    <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (pick_d) begin
                  state     <= BUSY_D;
                  a_address <= d_address;
                  a_wdata   <= d_wdata;
                  // read+write together is treated as a write
                  a_write   <= d_write;
                  a_read    <= ~d_write;
`ifdef CACHE_ARB_RR_EN
                  last_d    <= 1'b1;
`endif
               end else if (i_read) begin
                  state     <= BUSY_I;
                  a_address <= i_address;
                  a_wdata   <= 256'h0;
                  a_write   <= 1'b0;
                  a_read    <= 1'b1;
`ifdef CACHE_ARB_RR_EN
                  last_d    <= 1'b0;
`endif
               end
            end
            BUSY_I, BUSY_D: begin
               if (a_resp) begin
                  state   <= RECOVER;
                  a_read  <= 1'b0;
                  a_write <= 1'b0;
               end
            end
            // One dead cycle so a still-held request cannot retrigger at once
            RECOVER: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign i_resp  = (state == BUSY_I) & a_resp;
   assign d_resp  = (state == BUSY_D) & a_resp;
   assign i_rdata = a_rdata;
   assign d_rdata = a_rdata;
   assign busy    = (state != IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter with a scoreboard of expected grants.
// The bench plays the adaptor and compares each adaptor request to the queue.
module tb_cache_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic         i_read;
   logic [31:0]  i_address;
   logic         i_resp;
   logic [255:0] i_rdata;
   logic         d_read;
   logic         d_write;
   logic [31:0]  d_address;
   logic [255:0] d_wdata;
   logic         d_resp;
   logic [255:0] d_rdata;
   logic         a_read;
   logic         a_write;
   logic [31:0]  a_address;
   logic [255:0] a_wdata;
   logic [255:0] a_rdata;
   logic         a_resp;
   logic         busy;

   cache_arbiter dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_address(i_address),
      .i_resp(i_resp), .i_rdata(i_rdata),
      .d_read(d_read), .d_write(d_write),
      .d_address(d_address), .d_wdata(d_wdata),
      .d_resp(d_resp), .d_rdata(d_rdata),
      .a_read(a_read), .a_write(a_write),
      .a_address(a_address), .a_wdata(a_wdata),
      .a_rdata(a_rdata), .a_resp(a_resp),
      .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         is_d;
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] data;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   function automatic exp_t mk(logic is_d, logic wr,
                               logic [31:0] addr, logic [255:0] data);
      exp_t e;
      e.is_d = is_d;
      e.wr   = wr;
      e.addr = addr;
      e.data = data;
      return e;
   endfunction

   // Waits (bounded) for an adaptor request; cyc counts negedges from call.
   task automatic wait_req(output int cyc, output bit to);
      to  = 1'b1;
      cyc = -1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (a_read || a_write) begin
            cyc = i;
            to  = 1'b0;
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      a_rdata = {8{32'hDEAD_BEEF}};
      idle(2);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got %b want 0", busy);
      end
      checks++;
      if ({a_read, a_write, i_resp, d_resp} !== 4'b0) begin
         errors++;
         $display("FAIL reset_ctl got %b want 0000",
                  {a_read, a_write, i_resp, d_resp});
      end
      checks++;
      if (a_address !== 32'h0 || a_wdata !== 256'h0) begin
         errors++;
         $display("FAIL reset_addr got %h want 0", a_address);
      end
      checks++;
      if (i_rdata !== {8{32'hDEAD_BEEF}} || d_rdata !== {8{32'hDEAD_BEEF}}) begin
         errors++;
         $display("FAIL rdata_pass got %h want deadbeef..", i_rdata[31:0]);
      end
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_arbitration;
      int   cyc;
      bit   to;
      exp_t e;
      @(posedge clk);
      #1;
      i_read = 1'b1; i_address = 32'h0000_2000;
      d_read = 1'b1; d_address = 32'h0000_3000;
      d_wdata = 256'h0;
`ifdef CACHE_ARB_RR_EN
      sb.push_back(mk(1'b1, 1'b0, 32'h0000_3000, 256'h0));
      sb.push_back(mk(1'b0, 1'b0, 32'h0000_2000, 256'h0));
      sb.push_back(mk(1'b1, 1'b0, 32'h0000_3000, 256'h0));
`else
      repeat (3) sb.push_back(mk(1'b1, 1'b0, 32'h0000_3000, 256'h0));
`endif
      for (int k = 0; k < 3; k++) begin
         wait_req(cyc, to);
         checks++;
         if (to || sb.size() == 0) begin
            errors++;
            $display("FAIL arb_req%0d got timeout want request", k);
            continue;
         end
         e = sb.pop_front();
         checks++;
         if ({a_write, a_read, a_address} !== {e.wr, ~e.wr, e.addr}) begin
            errors++;
            $display("FAIL arb_grant%0d got addr %h want %h", k, a_address, e.addr);
         end
         checks++;
         if (cyc !== ((k == 0) ? 1 : 2)) begin
            errors++;
            $display("FAIL arb_gap%0d got %0d want %0d", k, cyc, (k == 0) ? 1 : 2);
         end
         @(posedge clk);
         #1 a_resp = 1'b1;
         @(negedge clk);
         checks++;
         if ({i_resp, d_resp} !== (e.is_d ? 2'b01 : 2'b10)) begin
            errors++;
            $display("FAIL arb_resp%0d got %b want %b", k, {i_resp, d_resp},
                     e.is_d ? 2'b01 : 2'b10);
         end
         @(posedge clk);
         #1 a_resp = 1'b0;
      end
      i_read = 1'b0;
      d_read = 1'b0;
      idle(3);
   endtask

   task automatic test_i_read;
      int   cyc;
      bit   to;
      bit   stable;
      exp_t e;
      i_read = 1'b1; i_address = 32'h0000_1000;
      sb.push_back(mk(1'b0, 1'b0, 32'h0000_1000, 256'h0));
      wait_req(cyc, to);
      checks++;
      if (to || cyc !== 1 || sb.size() == 0) begin
         errors++;
         $display("FAIL i_latency got %0d want 1", cyc);
      end else begin
         e = sb.pop_front();
         checks++;
         if ({a_read, a_write, a_address} !== {1'b1, 1'b0, e.addr}) begin
            errors++;
            $display("FAIL i_req got %b%b %h want 10 %h",
                     a_read, a_write, a_address, e.addr);
         end
      end
      stable = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (a_read !== 1'b1 || a_address !== 32'h0000_1000 || i_resp !== 1'b0)
            stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL i_hold got unstable want stable");
      end
      @(posedge clk);
      #1;
      a_resp = 1'b1;
      a_rdata = {8{32'h1234_5678}};
      @(negedge clk);
      checks++;
      if ({i_resp, d_resp} !== 2'b10 || i_rdata !== {8{32'h1234_5678}}) begin
         errors++;
         $display("FAIL i_resp got %b want 10", {i_resp, d_resp});
      end
      @(posedge clk);
      #1;
      a_resp = 1'b0;
      i_read = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, a_read, i_resp} !== 3'b100) begin
         errors++;
         $display("FAIL i_recover got %b want 100", {busy, a_read, i_resp});
      end
      @(negedge clk);
      checks++;
      if ({busy, a_read} !== 2'b00) begin
         errors++;
         $display("FAIL i_idle got %b want 00", {busy, a_read});
      end
      idle(1);
   endtask

   task automatic test_d_write;
      int   cyc;
      bit   to;
      bit   stable;
      exp_t e;
      d_write = 1'b1; d_address = 32'h8000_0040; d_wdata = {32{8'hA5}};
      sb.push_back(mk(1'b1, 1'b1, 32'h8000_0040, {32{8'hA5}}));
      wait_req(cyc, to);
      checks++;
      if (to || sb.size() == 0) begin
         errors++;
         $display("FAIL d_wr_req got timeout want request");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({a_write, a_read, a_address, a_wdata} !== {e.wr, ~e.wr, e.addr, e.data}) begin
            errors++;
            $display("FAIL d_wr_fields got %b%b %h want 10 %h",
                     a_write, a_read, a_address, e.addr);
         end
      end
      stable = 1'b1;
      repeat (3) begin
         @(negedge clk);
         if (a_write !== 1'b1 || a_address !== 32'h8000_0040 ||
             a_wdata !== {32{8'hA5}} || d_resp !== 1'b0)
            stable = 1'b0;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL d_wr_hold got unstable want stable");
      end
      @(posedge clk);
      #1 a_resp = 1'b1;
      @(negedge clk);
      checks++;
      if ({i_resp, d_resp} !== 2'b01) begin
         errors++;
         $display("FAIL d_wr_resp got %b want 01", {i_resp, d_resp});
      end
      @(posedge clk);
      #1;
      a_resp = 1'b0;
      d_write = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, a_write, d_resp} !== 3'b100) begin
         errors++;
         $display("FAIL d_wr_recover got %b want 100", {busy, a_write, d_resp});
      end
      idle(2);
   endtask

   task automatic test_back_to_back;
      int   cyc;
      bit   to;
      exp_t e;
      i_read = 1'b1; i_address = 32'h0000_5000;
      repeat (2) sb.push_back(mk(1'b0, 1'b0, 32'h0000_5000, 256'h0));
      for (int k = 0; k < 2; k++) begin
         wait_req(cyc, to);
         checks++;
         if (to || sb.size() == 0 || cyc !== ((k == 0) ? 1 : 2)) begin
            errors++;
            $display("FAIL b2b_gap%0d got %0d want %0d", k, cyc, (k == 0) ? 1 : 2);
            continue;
         end
         e = sb.pop_front();
         checks++;
         if ({a_read, a_address} !== {1'b1, e.addr}) begin
            errors++;
            $display("FAIL b2b_req%0d got %h want %h", k, a_address, e.addr);
         end
         @(posedge clk);
         #1 a_resp = 1'b1;
         @(posedge clk);
         #1 a_resp = 1'b0;
         if (k == 1) i_read = 1'b0;
      end
      idle(3);
   endtask

   task automatic test_rw_both;
      int   cyc;
      bit   to;
      exp_t e;
      d_read = 1'b1; d_write = 1'b1;
      d_address = 32'h0000_0040; d_wdata = {8{32'h0BAD_F00D}};
      sb.push_back(mk(1'b1, 1'b1, 32'h0000_0040, {8{32'h0BAD_F00D}}));
      wait_req(cyc, to);
      checks++;
      if (to || sb.size() == 0) begin
         errors++;
         $display("FAIL rw_req got timeout want request");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({a_write, a_read, a_address, a_wdata} !== {e.wr, 1'b0, e.addr, e.data}) begin
            errors++;
            $display("FAIL rw_op got w%b r%b want w1 r0", a_write, a_read);
         end
      end
      @(posedge clk);
      #1 a_resp = 1'b1;
      @(posedge clk);
      #1;
      a_resp = 1'b0;
      d_read = 1'b0;
      d_write = 1'b0;
      idle(3);
   endtask

   task automatic test_reset_mid;
      int   cyc;
      bit   to;
      exp_t e;
      d_read = 1'b1; d_address = 32'h0000_4000;
      sb.push_back(mk(1'b1, 1'b0, 32'h0000_4000, 256'h0));
      wait_req(cyc, to);
      checks++;
      if (to || sb.size() == 0) begin
         errors++;
         $display("FAIL rm_req got timeout want request");
      end else begin
         e = sb.pop_front();
         checks++;
         if ({a_read, a_address} !== {1'b1, e.addr}) begin
            errors++;
            $display("FAIL rm_fields got %h want %h", a_address, e.addr);
         end
      end
      @(negedge clk);
      @(posedge clk);
      #1;
      rst = 1'b1;
      d_read = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      a_resp = 1'b1;
      @(negedge clk);
      checks++;
      if ({busy, a_read, a_write, i_resp, d_resp} !== 5'b0 || a_address !== 32'h0) begin
         errors++;
         $display("FAIL rm_clear got %b want 00000",
                  {busy, a_read, a_write, i_resp, d_resp});
      end
      @(posedge clk);
      #1 a_resp = 1'b0;
      @(negedge clk);
      checks++;
      if ({busy, d_resp} !== 2'b00) begin
         errors++;
         $display("FAIL rm_stray got %b want 00", {busy, d_resp});
      end
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL sb_empty got %0d want 0", sb.size());
      end
   endtask

   initial begin
      rst = 1'b1;
      i_read = 1'b0; i_address = 32'h0;
      d_read = 1'b0; d_write = 1'b0;
      d_address = 32'h0; d_wdata = 256'h0;
      a_rdata = 256'h0; a_resp = 1'b0;
      test_reset;
      test_arbitration;
      test_i_read;
      test_d_write;
      test_back_to_back;
      test_rw_both;
      test_reset_mid;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
